// File: rtl/risk_bus_pkg.sv
// Shared definitions for the data-bus arbiter: bus widths and FSM state encoding.
package risk_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP,
    S_LOCKED = ST_LOCKED
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the master that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Grant decode
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-RAM port: round-robin grant, optional bus locking
// with forced release, and a fixed one-cycle synchronous-read slave.
module dmem_arbiter
  import risk_bus_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_lock,
  input  logic [BUS_AW-1:0] i_m0_addr,
  input  logic [BUS_DW-1:0] i_m0_wdata,
  input  logic [BUS_SW-1:0] i_m0_wr,
  output logic              o_m0_ack,
  output logic [BUS_DW-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_lock,
  input  logic [BUS_AW-1:0] i_m1_addr,
  input  logic [BUS_DW-1:0] i_m1_wdata,
  input  logic [BUS_SW-1:0] i_m1_wr,
  output logic              o_m1_ack,
  output logic [BUS_DW-1:0] o_m1_rdata,
  output logic [BUS_AW-1:0] o_s_addr,
  output logic [BUS_DW-1:0] o_s_wdata,
  output logic [BUS_SW-1:0] o_s_wr,
  output logic              o_s_rd,
  input  logic [BUS_DW-1:0] i_s_rdata,
  output logic              o_owner,
  output logic              o_busy
);

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX - 32'd1);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;

  logic              gnt_valid, gnt_idx;
  logic              own_req, own_lock;
  logic [BUS_AW-1:0] own_addr;
  logic [BUS_DW-1:0] own_wdata;
  logic [BUS_SW-1:0] own_wr;

  rr_pick2 u_pick (
    .req       ({i_m1_req, i_m0_req}),
    .last      (last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign own_req   = owner_q ? i_m1_req   : i_m0_req;
  assign own_lock  = owner_q ? i_m1_lock  : i_m0_lock;
  assign own_addr  = owner_q ? i_m1_addr  : i_m0_addr;
  assign own_wdata = owner_q ? i_m1_wdata : i_m0_wdata;
  assign own_wr    = owner_q ? i_m1_wr    : i_m0_wr;

  // Next-state logic for FSM, owner, round-robin pointer and lock counter
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        last_grant_d = owner_q;
        // Forced release once LOCK_MAX transactions have run under one lock
        if (own_lock && (lock_cnt_q < LOCK_LIM)) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
          state_d    = S_LOCKED;
        end else begin
          lock_cnt_d = 8'd0;
          state_d    = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (own_req) begin
          state_d = S_ACCESS;
        end else if (!own_lock) begin
          lock_cnt_d = 8'd0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_LOCKED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // Slave bus is only driven in ACCESS, giving one strobe per transaction
  always_comb begin
    if (state_q == S_ACCESS) begin
      o_s_addr  = own_addr;
      o_s_wdata = own_wdata;
      o_s_wr    = own_wr;
      o_s_rd    = (own_wr == 4'b0000);
    end else begin
      o_s_addr  = '0;
      o_s_wdata = '0;
      o_s_wr    = 4'b0000;
      o_s_rd    = 1'b0;
    end
  end

  assign o_m0_ack   = (state_q == S_RESP) && !owner_q;
  assign o_m1_ack   = (state_q == S_RESP) && owner_q;
  assign o_m0_rdata = o_m0_ack ? i_s_rdata : 32'h0000_0000;
  assign o_m1_rdata = o_m1_ack ? i_s_rdata : 32'h0000_0000;
  assign o_owner    = owner_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single data-RAM port of the SoC top level. It shares the RAM data port between the CPU data port (master 0) and a second bus master (master 1), such as a UART loader or DMA engine. It serialises their transactions with a round-robin policy, optional bus locking for read-modify-write sequences, and a fixed 1-cycle synchronous-read slave. Address decode and the I/O mux remain in the top level; this block sits between the masters and the RAM/peripheral data bus.

## Interface
- LOCK_MAX, 16: maximum consecutive locked transactions before the arbiter forces a release (1..255).
- i_clk  in  1  system clock; all state updates on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_m0_req / i_m1_req  in  1  transaction request; held high with its command until the matching ack.
- i_m0_lock / i_m1_lock  in  1  keep ownership after the current transaction.
- i_m0_addr / i_m1_addr  in  32  byte address.
- i_m0_wdata / i_m1_wdata  in  32  write data.
- i_m0_wr / i_m1_wr  in  4  byte write strobes; 4'b0000 means read.
- o_m0_ack / o_m1_ack  out  1  one-cycle completion pulse.
- o_m0_rdata / o_m1_rdata  out  32  read data, valid only while the matching ack is high; otherwise 0.
- o_s_addr  out  32  slave address.
- o_s_wdata  out  32  slave write data.
- o_s_wr  out  4  slave byte strobes.
- o_s_rd  out  1  slave read strobe.
- i_s_rdata  in  32  slave read data, valid the cycle after the strobe.
- o_owner  out  1  current or last owner index.
- o_busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - ACCESS: drive the slave.
  - RESP: capture data and ack.
  - LOCKED: hold ownership.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the master that is not `last_grant`.
  - On any grant: latch the winner in `owner` and go to ACCESS.
- ACCESS:
  - o_s_addr, o_s_wdata and o_s_wr are driven from the owner's inputs.
  - o_s_rd = (owner wr == 0).
  - Go to RESP unconditionally; a granted transaction is committed even if req drops (that is a protocol violation).
- RESP:
  - Owner's o_mX_ack = 1 and o_mX_rdata = i_s_rdata; the other master sees ack = 0 and rdata = 0.
  - last_grant <= owner.
  - If the owner's lock is high and lock_cnt < LOCK_MAX - 1: lock_cnt++ and go to LOCKED.
  - Otherwise: lock_cnt <= 0 and go to IDLE.
- LOCKED:
  - Owner req high: go to ACCESS (the other master is ignored).
  - Owner lock low: lock_cnt <= 0 and go to IDLE.
  - Otherwise: wait in LOCKED.
- Slave strobes are 0 in every state except ACCESS, so there is exactly one write strobe per transaction.
- The master must drop req or present a new command in the cycle after its ack. While it is in IDLE the stale req is not re-sampled, because the state is IDLE only from the cycle after RESP.

## Timing
- Reset values:
  - State: IDLE.
  - owner = 0, last_grant = 1 (master 0 wins the first contention).
  - lock_cnt = 0.
  - All o_* outputs = 0.
- Latency: req seen in IDLE in cycle N → slave strobe in N+1 → ack with rdata in N+2.
- Unlocked throughput: 1 transaction per 3 cycles.
- Locked back-to-back throughput (RESP → LOCKED → ACCESS): 1 transaction per 3 cycles, with no interleaving.
- Reset mid-transaction:
  - Next state is IDLE; no ack is issued.
  - A pending write strobe ends in the reset cycle.
  - A write already strobed in ACCESS is not undone.
- Simultaneous requests with last_grant = 0: m1 is granted; after it completes, a still-pending m0 is granted next.
- Lock forced release: after LOCK_MAX locked transactions the arbiter returns to IDLE even if lock is high, so the other master can win round-robin.
- Slave outputs are combinational from state and owner; the ack is registered-free (decoded from state).

## Structure
- Shared package `risk_bus_pkg`:
  - State encoding localparams ST_IDLE, ST_ACCESS, ST_RESP, ST_LOCKED.
  - Bus width constants BUS_AW = 32, BUS_DW = 32, BUS_SW = 4.
- Sub-module `rr_pick2`: a combinational round-robin picker with inputs (req[1:0], last) and outputs (gnt_valid, gnt_idx).
- Everything else is in `dmem_arbiter`: the FSM, lock counter and output muxing.

## Test plan
- Single read: m0 reads 0x00000040, slave returns 0xDEADBEEF → o_s_rd in cycle 1, o_m0_ack with rdata 0xDEADBEEF in cycle 2, o_m1_rdata = 0.
- Contention after reset: both request in the same cycle → m0 is served first, then m1; acks 3 cycles apart; o_owner follows.
- Round-robin fairness: both hold req continuously for 6 transactions → grants alternate 0,1,0,1,0,1.
- Byte write: m1 writes wr = 4'b0100, wdata 0x00AB0000 to 0x100 → o_s_wr = 4'b0100 for exactly one cycle, o_s_rd = 0, ack 1 cycle later.
- Lock with LOCK_MAX = 4: m0 holds lock and req while m1 requests → 4 m0 transactions, then m1 is granted.
- Reset in ACCESS: assert i_rst during a write → no ack, o_busy = 0 and all strobes 0 next cycle, and a fresh m1 request is granted with the normal 2-cycle latency.
